// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and derived totals. The background and sprite stages
// size their images from IMAGE_WIDTH/IMAGE_HEIGHT.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int timingTotal(input int visible, input int front,
                                     input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL      = timingTotal(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int V_TOTAL      = timingTotal(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;
  localparam int IMAGE_WIDTH  = DEF_H_VISIBLE;
  localparam int IMAGE_HEIGHT = DEF_V_VISIBLE;

  // Half-open window test [lo, hi) used for sync and visible regions.
  function automatic logic inWindow(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: the timing generator drives it, display stages consume it.
interface vga_timing_if;
  import vga_pkg::*;

  logic   pixel_ce;
  coord_t DrawX;
  coord_t DrawY;
  logic   hs;
  logic   vs;
  logic   blank_n;
  logic   frame_start;

  modport master (output pixel_ce, DrawX, DrawY, hs, vs, blank_n, frame_start);
  modport slave  (input  pixel_ce, DrawX, DrawY, hs, vs, blank_n, frame_start);

endinterface

// File: rtl/vga_timing.sv
// VGA raster counter: pixel-rate enable, DrawX/DrawY position, and registered
// syncs/blanking that are computed from the next count so all outputs move together.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic         Clk,
  input  logic         Reset,
  vga_timing_if.master vga
);

  localparam int     LINE_LEN    = timingTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int     FRAME_LINES = timingTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam coord_t H_LAST      = coord_t'(LINE_LEN - 1);
  localparam coord_t V_LAST      = coord_t'(FRAME_LINES - 1);
  localparam coord_t HS_START    = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END      = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START    = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END      = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t H_VIS_END   = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END   = coord_t'(V_VISIBLE);

  logic   pixelCe_q;
  coord_t drawX_q, drawX_d;
  coord_t drawY_q, drawY_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   blankN_q, blankN_d;
  logic   frameStart_q, frameStart_d;

  // Using >= on the wrap compare keeps the counters inside the frame even from a bad state.
  always_comb begin
    drawX_d      = drawX_q;
    drawY_d      = drawY_q;
    frameStart_d = 1'b0;
    if (pixelCe_q) begin
      if (drawX_q >= H_LAST) begin
        drawX_d = '0;
        if (drawY_q >= V_LAST) begin
          drawY_d      = '0;
          frameStart_d = 1'b1;
        end else begin
          drawY_d = drawY_q + 10'd1;
        end
      end else begin
        drawX_d = drawX_q + 10'd1;
      end
    end
    hs_d     = !inWindow(drawX_d, HS_START, HS_END);
    vs_d     = !inWindow(drawY_d, VS_START, VS_END);
    blankN_d = (drawX_d < H_VIS_END) && (drawY_d < V_VIS_END);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixelCe_q    <= 1'b0;
      drawX_q      <= '0;
      drawY_q      <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      blankN_q     <= 1'b1;
      frameStart_q <= 1'b0;
    end else begin
      pixelCe_q    <= ~pixelCe_q;
      drawX_q      <= drawX_d;
      drawY_q      <= drawY_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blankN_q     <= blankN_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign vga.pixel_ce    = pixelCe_q;
  assign vga.DrawX       = drawX_q;
  assign vga.DrawY       = drawY_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank_n     = blankN_q;
  assign vga.frame_start = frameStart_q;

  // Downstream stages index memories with these, so out-of-frame values must never appear.
  assert property (@(posedge Clk) disable iff (Reset) (int'(drawX_q) < LINE_LEN))
    else $error("DrawX out of range");
  assert property (@(posedge Clk) disable iff (Reset) (int'(drawY_q) < FRAME_LINES))
    else $error("DrawY out of range");

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance for line-level timing and a tiny
// 8x4 instance for whole-frame behaviour, both checked against hand-computed values.
module tb_vga_timing;

  logic Clk = 1'b0;
  logic resetBig;
  logic resetSmall;

  vga_timing_if vgaBig();
  vga_timing_if vgaSmall();

  vga_timing dutBig (
    .Clk   (Clk),
    .Reset (resetBig),
    .vga   (vgaBig.master)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dutSmall (
    .Clk   (Clk),
    .Reset (resetSmall),
    .vga   (vgaSmall.master)
  );

  always #10 Clk = ~Clk;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    int   k;
    int   x;
    int   y;
    logic ce;
    logic hs;
    logic vs;
    logic bn;
    logic fs;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input int k, input int x, input int y, input logic ce,
                        input logic hs, input logic vs, input logic bn, input logic fs);
    vec_t v;
    v.k = k; v.x = x; v.y = y; v.ce = ce; v.hs = hs; v.vs = vs; v.bn = bn; v.fs = fs;
    vecs.push_back(v);
  endtask

  task automatic checkResetState(input string tag, input bit useSmall);
    int x, y, ce, hs, vs, bn, fs;
    if (useSmall) begin
      x = int'(vgaSmall.DrawX); y = int'(vgaSmall.DrawY); ce = int'(vgaSmall.pixel_ce);
      hs = int'(vgaSmall.hs); vs = int'(vgaSmall.vs); bn = int'(vgaSmall.blank_n);
      fs = int'(vgaSmall.frame_start);
    end else begin
      x = int'(vgaBig.DrawX); y = int'(vgaBig.DrawY); ce = int'(vgaBig.pixel_ce);
      hs = int'(vgaBig.hs); vs = int'(vgaBig.vs); bn = int'(vgaBig.blank_n);
      fs = int'(vgaBig.frame_start);
    end
    checkOutput({tag, " DrawX"}, x, 0);
    checkOutput({tag, " DrawY"}, y, 0);
    checkOutput({tag, " pixel_ce"}, ce, 0);
    checkOutput({tag, " hs"}, hs, 1);
    checkOutput({tag, " vs"}, vs, 1);
    checkOutput({tag, " blank_n"}, bn, 1);
    checkOutput({tag, " frame_start"}, fs, 0);
  endtask

  // Expected small-instance outputs k Clk edges after reset release.
  // Line = 14 pixels = 28 Clk, frame = 7 lines = 196 Clk.
  task automatic applyStimulus();
    addVec(0,   0,  0, 0, 1, 1, 1, 0);
    addVec(1,   0,  0, 1, 1, 1, 1, 0);
    addVec(2,   1,  0, 0, 1, 1, 1, 0);
    addVec(3,   1,  0, 1, 1, 1, 1, 0);
    addVec(15,  7,  0, 1, 1, 1, 1, 0);
    addVec(16,  8,  0, 0, 1, 1, 0, 0);
    addVec(20, 10,  0, 0, 0, 1, 0, 0);
    addVec(23, 11,  0, 1, 0, 1, 0, 0);
    addVec(24, 12,  0, 0, 1, 1, 0, 0);
    addVec(27, 13,  0, 1, 1, 1, 0, 0);
    addVec(28,  0,  1, 0, 1, 1, 1, 0);
    addVec(56,  0,  2, 0, 1, 1, 1, 0);
    addVec(112, 0,  4, 0, 1, 1, 0, 0);
    addVec(140, 0,  5, 0, 1, 0, 0, 0);
    addVec(141, 0,  5, 1, 1, 0, 0, 0);
    addVec(168, 0,  6, 0, 1, 1, 0, 0);
    addVec(195, 13, 6, 1, 1, 1, 0, 0);
    addVec(196, 0,  0, 0, 1, 1, 1, 1);
    addVec(197, 0,  0, 1, 1, 1, 1, 0);
    addVec(198, 1,  0, 0, 1, 1, 1, 0);
    addVec(392, 0,  0, 0, 1, 1, 1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int hsLow, hsFirst, hsLast, bnFallX, xBefore, yBefore, rangeErr, fsSeen;
    int vsLow, bnErr, fsCount, fsAt, budget;
    bit found;

    resetBig   = 1'b1;
    resetSmall = 1'b1;
    applyStimulus();
    repeat (3) @(negedge Clk);
    checkResetState("big reset", 1'b0);
    checkResetState("small reset", 1'b1);

    // ---- Default instance: release and first pixels ----
    resetBig = 1'b0;
    checkOutput("big k0 pixel_ce", int'(vgaBig.pixel_ce), 0);
    checkOutput("big k0 DrawX", int'(vgaBig.DrawX), 0);
    @(negedge Clk);
    checkOutput("big k1 pixel_ce", int'(vgaBig.pixel_ce), 1);
    checkOutput("big k1 DrawX", int'(vgaBig.DrawX), 0);
    checkOutput("big k1 frame_start", int'(vgaBig.frame_start), 0);
    @(negedge Clk);
    checkOutput("big k2 pixel_ce", int'(vgaBig.pixel_ce), 0);
    checkOutput("big k2 DrawX", int'(vgaBig.DrawX), 1);
    @(negedge Clk);
    checkOutput("big k3 pixel_ce", int'(vgaBig.pixel_ce), 1);
    checkOutput("big k3 DrawX", int'(vgaBig.DrawX), 1);
    @(negedge Clk);
    checkOutput("big k4 DrawX", int'(vgaBig.DrawX), 2);
    checkOutput("big k4 DrawY", int'(vgaBig.DrawY), 0);

    // ---- Default instance: one full line ----
    hsLow = 0; hsFirst = -1; hsLast = -1; bnFallX = -1;
    xBefore = -1; yBefore = -1; rangeErr = 0; fsSeen = 0;
    for (int kk = 5; kk <= 1600; kk++) begin
      @(negedge Clk);
      if (!vgaBig.hs) begin
        hsLow++;
        if (hsFirst < 0) hsFirst = int'(vgaBig.DrawX);
        hsLast = int'(vgaBig.DrawX);
      end
      if (!vgaBig.blank_n && bnFallX < 0) bnFallX = int'(vgaBig.DrawX);
      if (vgaBig.DrawX >= 10'd800 || vgaBig.DrawY >= 10'd525) rangeErr++;
      if (vgaBig.frame_start) fsSeen++;
      if (kk == 1599) begin
        xBefore = int'(vgaBig.DrawX);
        yBefore = int'(vgaBig.DrawY);
      end
    end
    checkOutput("line hs low Clk count", hsLow, 192);
    checkOutput("line hs first low DrawX", hsFirst, 656);
    checkOutput("line hs last low DrawX", hsLast, 751);
    checkOutput("line blank_n fall DrawX", bnFallX, 640);
    checkOutput("line DrawX before wrap", xBefore, 799);
    checkOutput("line DrawY before wrap", yBefore, 0);
    checkOutput("line DrawX after wrap", int'(vgaBig.DrawX), 0);
    checkOutput("line DrawY after wrap", int'(vgaBig.DrawY), 1);
    checkOutput("line blank_n after wrap", int'(vgaBig.blank_n), 1);
    checkOutput("line range errors", rangeErr, 0);
    checkOutput("line frame_start pulses", fsSeen, 0);

    // ---- Default instance: asynchronous reset mid-line ----
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge Clk);
      if (vgaBig.DrawX == 10'd300) found = 1'b1;
    end
    checkOutput("big reach DrawX=300", int'(found), 1);
    checkOutput("big DrawY at mid-line reset", int'(vgaBig.DrawY), 1);
    #5 resetBig = 1'b1;
    #1 checkResetState("big async reset", 1'b0);
    fsSeen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (vgaBig.frame_start || vgaBig.DrawX != 10'd0) fsSeen++;
    end
    checkOutput("big held reset stays idle", fsSeen, 0);
    resetBig = 1'b0;
    checkOutput("big rel k0 DrawX", int'(vgaBig.DrawX), 0);
    @(negedge Clk);
    checkOutput("big rel k1 DrawX", int'(vgaBig.DrawX), 0);
    checkOutput("big rel k1 pixel_ce", int'(vgaBig.pixel_ce), 1);
    @(negedge Clk);
    checkOutput("big rel k2 DrawX", int'(vgaBig.DrawX), 1);
    checkOutput("big rel k2 DrawY", int'(vgaBig.DrawY), 0);
    fsSeen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (vgaBig.frame_start) fsSeen++;
    end
    checkOutput("big no frame_start after reset", fsSeen, 0);

    // ---- Small instance: directed vector table ----
    resetSmall = 1'b0;
    k = 0;
    foreach (vecs[i]) begin
      while (k < vecs[i].k) begin
        @(negedge Clk);
        k++;
      end
      checkOutput($sformatf("vec k=%0d DrawX", vecs[i].k), int'(vgaSmall.DrawX), vecs[i].x);
      checkOutput($sformatf("vec k=%0d DrawY", vecs[i].k), int'(vgaSmall.DrawY), vecs[i].y);
      checkOutput($sformatf("vec k=%0d pixel_ce", vecs[i].k), int'(vgaSmall.pixel_ce), int'(vecs[i].ce));
      checkOutput($sformatf("vec k=%0d hs", vecs[i].k), int'(vgaSmall.hs), int'(vecs[i].hs));
      checkOutput($sformatf("vec k=%0d vs", vecs[i].k), int'(vgaSmall.vs), int'(vecs[i].vs));
      checkOutput($sformatf("vec k=%0d blank_n", vecs[i].k), int'(vgaSmall.blank_n), int'(vecs[i].bn));
      checkOutput($sformatf("vec k=%0d frame_start", vecs[i].k), int'(vgaSmall.frame_start), int'(vecs[i].fs));
    end

    // ---- Small instance: one whole frame from the frame_start at k=392 ----
    hsLow = 0; vsLow = 0; bnErr = 0; rangeErr = 0; fsCount = 0; fsAt = -1;
    for (int n = 1; n <= 196; n++) begin
      @(negedge Clk);
      if (!vgaSmall.hs) hsLow++;
      if (!vgaSmall.vs) vsLow++;
      if (vgaSmall.blank_n != ((vgaSmall.DrawX < 10'd8) && (vgaSmall.DrawY < 10'd4))) bnErr++;
      if (vgaSmall.DrawX >= 10'd14 || vgaSmall.DrawY >= 10'd7) rangeErr++;
      if (vgaSmall.frame_start) begin
        fsCount++;
        fsAt = n;
        if (vgaSmall.DrawX != 10'd0 || vgaSmall.DrawY != 10'd0) rangeErr++;
      end
    end
    checkOutput("frame hs low Clk count", hsLow, 28);
    checkOutput("frame vs low Clk count", vsLow, 28);
    checkOutput("frame blank_n errors", bnErr, 0);
    checkOutput("frame range/origin errors", rangeErr, 0);
    checkOutput("frame frame_start count", fsCount, 1);
    checkOutput("frame frame_start period", fsAt, 196);

    // ---- Small instance: asynchronous reset mid-frame ----
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge Clk);
      if (vgaSmall.DrawX == 10'd6 && vgaSmall.DrawY == 10'd2) found = 1'b1;
    end
    checkOutput("small reach (6,2)", int'(found), 1);
    #5 resetSmall = 1'b1;
    #1 checkResetState("small async reset", 1'b1);
    repeat (3) @(negedge Clk);
    resetSmall = 1'b0;
    fsSeen = 0;
    budget = 0;
    for (int n = 1; n <= 28; n++) begin
      @(negedge Clk);
      if (vgaSmall.frame_start) fsSeen++;
      if (n == 1 && vgaSmall.DrawX != 10'd0) budget++;
      if (n == 2 && vgaSmall.DrawX != 10'd1) budget++;
    end
    checkOutput("small restart early DrawX errors", budget, 0);
    checkOutput("small restart no frame_start", fsSeen, 0);
    checkOutput("small restart k28 DrawX", int'(vgaSmall.DrawX), 0);
    checkOutput("small restart k28 DrawY", int'(vgaSmall.DrawY), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
